// File: rtl/seg_scan_hex_if.sv
// Bus between the datapath/status registers and the multiplexed 7-segment driver.
// The master supplies value/dp/load/lz_en; the slave returns segment and anode drives.
interface seg_scan_hex_if #(
    parameter int unsigned DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp_in;
    logic                load;
    logic                lz_en;
    logic [7:0]          segout;
    logic [DIGITS-1:0]   an;
    logic                frame_start;

    modport master (
        output value,
        output dp_in,
        output load,
        output lz_en,
        input  segout,
        input  an,
        input  frame_start
    );

    modport slave (
        input  value,
        input  dp_in,
        input  load,
        input  lz_en,
        output segout,
        output an,
        output frame_start
    );
endinterface

// File: rtl/seg_scan_hex.sv
// Time-multiplexed hex driver for a common-anode multi-digit 7-segment display with
// frame-synchronous value updates, leading-zero blanking and a per-slot ghost guard.
module seg_scan_hex #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_hex_if.slave bus
);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ValW = 4 * DIGITS;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam logic [IdxW-1:0] IdxMax = IdxW'(DIGITS - 1);

    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [ValW-1:0]   shadow_val_q, shadow_val_d;
    logic [DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic              pending_q, pending_d;
    logic [ValW-1:0]   disp_val_q, disp_val_d;
    logic [DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic              fs_arm_q, fs_arm_d;
    logic [7:0]        segout_q, segout_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic              frame_start_q, frame_start_d;

    logic              slot_end;
    logic              wrap;
    logic              zero_above;
    logic [DIGITS-1:0] blank;
    logic [3:0]        sel_nib;
    logic              sel_dp;
    logic              sel_blank;
    logic [6:0]        seg7;

    always_comb begin
        slot_end = (cnt_q == CntMax);
        wrap     = slot_end && (idx_q == IdxMax);

        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end

        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
            pending_d    = 1'b1;
        end
        // A load coinciding with the wrap bypasses the shadow so it lands this frame.
        if (wrap) begin
            if (bus.load) begin
                disp_val_d = bus.value;
                disp_dp_d  = bus.dp_in;
            end else if (pending_q) begin
                disp_val_d = shadow_val_q;
                disp_dp_d  = shadow_dp_q;
            end
            pending_d = 1'b0;
        end

        // Walk from the top digit down; a digit blanks while everything above it is zero.
        zero_above = 1'b1;
        blank      = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above & (disp_val_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                blank[k] = zero_above;
            end
        end

        sel_nib   = 4'h0;
        sel_dp    = 1'b0;
        sel_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IdxW'(k)) begin
                sel_nib   = disp_val_q[4*k +: 4];
                sel_dp    = disp_dp_q[k];
                sel_blank = blank[k];
            end
        end

        unique case (sel_nib)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h18;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h27;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase

        segout_d = {~sel_dp, (bus.lz_en && sel_blank) ? 7'h7F : seg7};
        // First cycle of every slot keeps all anodes off to hide segment transitions.
        an_d     = (cnt_q == '0) ? '1 : ~(DIGITS'(1) << idx_q);

        // Two-stage delay lines frame_start up with the digit-0 guard cycle on the pins.
        fs_arm_d      = wrap;
        frame_start_d = fs_arm_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_val_q  <= '0;
            shadow_dp_q   <= '0;
            pending_q     <= 1'b0;
            disp_val_q    <= '0;
            disp_dp_q     <= '0;
            fs_arm_q      <= 1'b0;
            segout_q      <= 8'hFF;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_val_q  <= shadow_val_d;
            shadow_dp_q   <= shadow_dp_d;
            pending_q     <= pending_d;
            disp_val_q    <= disp_val_d;
            disp_dp_q     <= disp_dp_d;
            fs_arm_q      <= fs_arm_d;
            segout_q      <= segout_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.segout      = segout_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;
endmodule
